// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin output arbiter with registered link output
// Optional Local priority with starvation guard: define NOC_ARB_LOCAL_PRIO_EN.
module noc_output_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] req_data,
  input  logic [4:0]   req_valid,
  output logic [4:0]   req_ready,
  output logic [31:0]  out_packet,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   grant_idx
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  logic [31:0] out_packet_q, out_packet_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  grant_idx_q, grant_idx_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;

  logic        load_en;
  logic        win_found;
  logic [2:0]  win_idx;
  logic        adv_ptr;

  // Returns {found, index} of the first set bit searching ptr, ptr+1, ... mod 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] mask, input logic [2:0] ptr);
    logic [3:0] r;
    int j;
    r = '0;
    for (int k = 4; k >= 0; k--) begin
      j = (int'(ptr) + k) % 5;
      if (mask[j]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

  assign load_en = !out_valid_q || out_ready;

`ifdef NOC_ARB_LOCAL_PRIO_EN
  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt_q [4];
  logic [7:0] wait_cnt_d [4];
  logic [3:0] starved;

  always_comb begin
    starved = '0;
    for (int i = 0; i < 4; i++) begin
      starved[i] = req_valid[i] && (wait_cnt_q[i] == LIMIT8);
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    adv_ptr   = 1'b1;
    if (|starved) begin
      {win_found, win_idx} = rr_pick({1'b0, starved}, rr_ptr_q);
    end else if (req_valid[4]) begin
      win_found = 1'b1;
      win_idx   = 3'd4;
      adv_ptr   = 1'b0;
    end else begin
      {win_found, win_idx} = rr_pick({1'b0, req_valid[3:0]}, rr_ptr_q);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && !req_ready[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT8) ? wait_cnt_q[i] : wait_cnt_q[i] + 8'd1;
      end else begin
        wait_cnt_d[i] = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) wait_cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end
`else
  always_comb begin
    adv_ptr = 1'b1;
    {win_found, win_idx} = rr_pick(req_valid, rr_ptr_q);
  end
`endif

  // State register: out_valid_q is the EMPTY/FULL state of the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_packet_q <= '0;
      out_valid_q  <= 1'b0;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_packet_q <= out_packet_d;
      out_valid_q  <= out_valid_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_comb begin
    out_packet_d = out_packet_q;
    out_valid_d  = out_valid_q;
    grant_idx_d  = grant_idx_q;
    rr_ptr_d     = rr_ptr_q;
    if (load_en) begin
      if (win_found) begin
        out_packet_d = req_data[int'(win_idx) * 32 +: 32];
        out_valid_d  = 1'b1;
        grant_idx_d  = win_idx;
        if (adv_ptr) rr_ptr_d = (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (load_en && win_found) req_ready = 5'b00001 << win_idx;
  end

  assign out_packet = out_packet_q;
  assign out_valid  = out_valid_q;
  assign grant_idx  = grant_idx_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - scoreboard bench for noc_output_arbiter
module tb_noc_output_arbiter;
`ifdef NOC_ARB_LOCAL_PRIO_EN
  localparam int LIM = 3;
`else
  localparam int LIM = 8;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [159:0] req_data = '0;
  logic [4:0]   req_valid = '0;
  logic [4:0]   req_ready;
  logic [31:0]  out_packet;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   grant_idx;

  noc_output_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .out_packet(out_packet), .out_valid(out_valid),
    .out_ready(out_ready), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_ptr = 0;
  int cnt [4] = '{0, 0, 0, 0};
  logic [31:0] exp_pkt[$];
  int exp_idx[$];
  logic [4:0] acc_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rr_first(input logic [4:0] mask, input int ptr);
    for (int k = 0; k < 5; k++) begin
      if (mask[(ptr + k) % 5]) return (ptr + k) % 5;
    end
    return -1;
  endfunction

  // Monitor: the queue holds what the output register must contain.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(exp_pkt.size() != 0));
      if (out_valid && exp_pkt.size() != 0) begin
        check("out_packet", out_packet, exp_pkt[0]);
        check("grant_idx", 32'(grant_idx), 32'(exp_idx[0]));
        if (out_ready) begin
          void'(exp_pkt.pop_front());
          void'(exp_idx.pop_front());
        end
      end
    end
  end

  // Reference model: decides acceptance from the rules and pushes the expected packet.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      acc_mask = '0;
    end else begin
      int w;
      logic adv;
      logic [4:0] starved;
      logic [4:0] exp_rdy;
      w = -1;
      adv = 1'b1;
      starved = '0;
`ifdef NOC_ARB_LOCAL_PRIO_EN
      for (int i = 0; i < 4; i++) starved[i] = req_valid[i] && (cnt[i] == LIM);
      if (starved != 0) w = rr_first(starved, m_ptr);
      else if (req_valid[4]) begin w = 4; adv = 1'b0; end
      else w = rr_first({1'b0, req_valid[3:0]}, m_ptr);
`else
      w = rr_first(req_valid, m_ptr);
`endif
      exp_rdy = (exp_pkt.size() == 0 && w >= 0) ? (5'b00001 << w) : 5'b00000;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 0) begin
        exp_pkt.push_back(req_data[w*32 +: 32]);
        exp_idx.push_back(w);
        if (adv) m_ptr = (w + 1) % 5;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !exp_rdy[i]) cnt[i] = (cnt[i] < LIM) ? cnt[i] + 1 : LIM;
        else cnt[i] = 0;
      end
      acc_mask = exp_rdy;
    end
  end

  // Requesters hold data until accepted; 'want' asks for a (new) packet on each lane.
  task automatic step(input logic [4:0] want, input logic rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (req_valid[i] && acc_mask[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && want[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*32 +: 32] = $urandom;
      end
    end
    out_ready = rdy;
  endtask

  task automatic drain();
    repeat (7) step(5'b00000, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_data;
    logic [4:0] macro_tbl [5];
    macro_tbl = '{5'b10000, 5'b10000, 5'b10000, 5'b00001, 5'b10000};

    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_packet", out_packet, 32'd0);
      check("rst_grant_idx", 32'(grant_idx), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    step(5'b00100, 1'b1);
    req_data[95:64] = 32'hDEADBEEF;
    @(negedge clk); #2;
    check("single_ready", 32'(req_ready), 32'b00100);
    step(5'b00000, 1'b1);
    @(negedge clk); #2;
    check("single_packet", out_packet, 32'hDEADBEEF);
    check("single_idx", 32'(grant_idx), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);
    drain();

    repeat (12) step(5'b11111, 1'b1);
    drain();

    step(5'b00001, 1'b1);
    req_data[31:0] = 32'h11;
    step(5'b00010, 1'b0);
    s_data = req_data[63:32];
    repeat (4) begin
      @(negedge clk); #2;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_packet", out_packet, 32'h11);
      step(5'b00010, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk); #2;
    check("bp_release_ready", 32'(req_ready), 32'b00010);
    step(5'b00000, 1'b1);
    @(negedge clk); #2;
    check("bp_release_packet", out_packet, s_data);
    drain();

`ifndef NOC_ARB_LOCAL_PRIO_EN
    step(5'b10000, 1'b1);
    step(5'b01001, 1'b1);
    @(negedge clk); #2;
    check("wrap_ready", 32'(req_ready), 32'b00001);
    drain();
`endif

    repeat (300) step(5'($urandom), ($urandom_range(0, 3) != 0));
    drain();

    repeat (3) step(5'b11111, 1'b1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    exp_pkt.delete();
    exp_idx.delete();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    acc_mask = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
`ifdef NOC_ARB_LOCAL_PRIO_EN
    check("post_rst_ready", 32'(req_ready), 32'b10000);
`else
    check("post_rst_ready", 32'(req_ready), 32'b00001);
`endif
    drain();

`ifdef NOC_ARB_LOCAL_PRIO_EN
    for (int k = 0; k < 5; k++) begin
      step(5'b10001, 1'b1);
      @(negedge clk); #2;
      check("starve_ready", 32'(req_ready), 32'(macro_tbl[k]));
    end
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
